word_splitter_32_5: RTL and testbench

WORD_SPLITTER_32_5 -- requirements
Module: word_splitter_32_5

---
 rtl/word_splitter_32_5_pkg.sv | 14 +
 rtl/word_splitter_32_5_if.sv | 26 ++
 rtl/word_splitter_32_5_chunk_select.sv | 24 ++
 rtl/word_splitter_32_5.sv | 83 ++++++++
 tb/tb_word_splitter_32_5.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/word_splitter_32_5_pkg.sv
// Shared constants and FSM encoding for the 32-to-5-bit word splitter.
package word_splitter_32_5_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned CHUNK_W    = 5;
  localparam int unsigned NUM_CHUNKS = 7;
  localparam int unsigned IDX_W      = 3;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_t;

endpackage

// File: rtl/word_splitter_32_5_if.sv
// Word-in / chunk-out handshake bundle for the word splitter.
interface word_splitter_32_5_if;
  import word_splitter_32_5_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_W-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [CHUNK_W-1:0]   out_data;
  logic [IDX_W-1:0]     out_index;
  logic                 out_last;
  logic                 busy;

  // master drives words in and consumes chunks; slave is the splitter
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, busy
  );

endinterface

// File: rtl/word_splitter_32_5_chunk_select.sv
// Combinational chunk mux: picks 5-bit chunk `index` of the held word, top chunk zero-padded.
module chunk_select_32_5
  import word_splitter_32_5_pkg::*;
(
  input  logic [WORD_W-1:0]  word,
  input  logic [IDX_W-1:0]   index,
  output logic [CHUNK_W-1:0] chunk
);

  always_comb begin
    chunk = '0;
    case (index)
      3'd0:    chunk = word[4:0];
      3'd1:    chunk = word[9:5];
      3'd2:    chunk = word[14:10];
      3'd3:    chunk = word[19:15];
      3'd4:    chunk = word[24:20];
      3'd5:    chunk = word[29:25];
      3'd6:    chunk = {3'b000, word[31:30]};
      default: chunk = '0;
    endcase
  end

endmodule

// File: rtl/word_splitter_32_5.sv
// Splits each accepted 32-bit word into seven 5-bit chunks, LSB-first or MSB-first.
module word_splitter_32_5
  import word_splitter_32_5_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  word_splitter_32_5_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_CHUNKS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]   index;
  logic [CHUNK_W-1:0] chunk;
  logic               send, last, out_hs, accept;

  // cnt_q counts emitted chunks; index maps it to chunk number per emission order
  assign send   = (state_q == StSend);
  assign last   = send && (cnt_q == LAST_CNT);
  assign index  = LSB_FIRST ? cnt_q : (LAST_CNT - cnt_q);
  assign out_hs = send && bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = !send || (out_hs && last);
  assign bus.out_valid = send;
  assign bus.busy      = send;
  assign bus.out_last  = last;
  assign bus.out_index = send ? index : '0;
  assign bus.out_data  = send ? chunk : '0;

  chunk_select_32_5 u_chunk_select (
    .word  (word_q),
    .index (index),
    .chunk (chunk)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSend;
          cnt_d   = '0;
          word_d  = bus.in_data;
        end
      end
      StSend: begin
        // a new word on the final handshake restarts the count without a bubble
        if (accept) begin
          cnt_d  = '0;
          word_d = bus.in_data;
        end else if (out_hs) begin
          if (last) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_word_splitter_32_5.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model,
// run on one LSB-first and one MSB-first instance sharing the same stimulus.
module tb_word_splitter_32_5;

  typedef struct {
    logic [4:0] data;
    logic [2:0] index;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t qa[$];
  exp_t qb[$];

  word_splitter_32_5_if bus_a ();
  word_splitter_32_5_if bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.out_ready = out_ready;

  word_splitter_32_5 #(.LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  word_splitter_32_5 #(.LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [4:0] chunk_of(input logic [31:0] w, input int k);
    logic [31:0] s;
    s = w >> (5 * k);
    return s[4:0];
  endfunction

  // Model: each accepted word becomes seven expected chunks in emission order.
  task automatic sb_step(input bit which, input logic iv, input logic ir, input logic [31:0] id,
                         input logic ov, input logic orr, input logic [4:0] od,
                         input logic [2:0] oi, input logic ol);
    exp_t e;
    int   sz;
    sz = which ? qb.size() : qa.size();
    if (ov) begin
      if (sz == 0) begin
        check(which ? "b_unexpected_chunk" : "a_unexpected_chunk", 32'(ov), 32'd0);
      end else begin
        e = which ? qb[0] : qa[0];
        check(which ? "b_sb_data" : "a_sb_data", 32'(od), 32'(e.data));
        check(which ? "b_sb_index" : "a_sb_index", 32'(oi), 32'(e.index));
        check(which ? "b_sb_last" : "a_sb_last", 32'(ol), 32'(e.last));
        if (orr) begin
          if (which) void'(qb.pop_front());
          else void'(qa.pop_front());
        end
      end
    end else begin
      check(which ? "b_idle_outputs" : "a_idle_outputs", {23'd0, od, oi, ol}, 32'd0);
    end
    if (iv && ir) begin
      for (int k = 0; k < 7; k++) begin
        int kk;
        kk      = which ? 6 - k : k;
        e.data  = chunk_of(id, kk);
        e.index = 3'(kk);
        e.last  = (k == 6);
        if (which) qb.push_back(e);
        else qa.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      sb_step(1'b0, in_valid, bus_a.in_ready, in_data, bus_a.out_valid, out_ready,
              bus_a.out_data, bus_a.out_index, bus_a.out_last);
      sb_step(1'b1, in_valid, bus_b.in_ready, in_data, bus_b.out_valid, out_ready,
              bus_b.out_data, bus_b.out_index, bus_b.out_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_word(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  // Both instances hold w with out_ready high; checks all seven chunks and the idle after.
  task automatic expect_word(input string tag, input logic [31:0] w);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check({tag, "_a_data"}, 32'(bus_a.out_data), 32'(chunk_of(w, k)));
      check({tag, "_a_index"}, 32'(bus_a.out_index), 32'(k));
      check({tag, "_a_last"}, 32'(bus_a.out_last), 32'(k == 6));
      check({tag, "_b_data"}, 32'(bus_b.out_data), 32'(chunk_of(w, 6 - k)));
      check({tag, "_b_index"}, 32'(bus_b.out_index), 32'(6 - k));
      check({tag, "_b_last"}, 32'(bus_b.out_last), 32'(k == 6));
      tick();
    end
    @(negedge clk);
    check({tag, "_done_valid"}, {30'd0, bus_a.out_valid, bus_b.out_valid}, 32'd0);
    tick();
  endtask

  task automatic drain();
    int n;
    n         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((bus_a.busy || bus_b.busy) && n < 50) begin
      tick();
      n++;
    end
    check("drain_bounded", 32'(n < 50), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a"}, {25'd0, bus_a.out_valid, bus_a.busy, bus_a.out_last,
                        bus_a.out_index, bus_a.in_ready}, 32'd1);
    check({tag, "_b"}, {25'd0, bus_b.out_valid, bus_b.busy, bus_b.out_last,
                        bus_b.out_index, bus_b.in_ready}, 32'd1);
    check({tag, "_data"}, {22'd0, bus_a.out_data, bus_b.out_data}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");
    tick();

    // Known sequence, plus latency of one clock to the first chunk
    out_ready = 1'b1;
    start_word(32'h1234_5678);
    expect_word("w12345678", 32'h1234_5678);
    check("ref_chunk2", 32'(chunk_of(32'h1234_5678, 2)), 32'd21);

    start_word(32'hFFFF_FFFF);
    expect_word("wffffffff", 32'hFFFF_FFFF);

    // Stall at index 2 for four cycles
    start_word(32'h1234_5678);
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_data", 32'(bus_a.out_data), 32'd21);
      check("stall_index", 32'(bus_a.out_index), 32'd2);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_data", 32'(bus_a.out_data), 32'd21);
    tick();
    @(negedge clk);
    check("resume_data", 32'(bus_a.out_data), 32'd8);
    check("resume_index", 32'(bus_a.out_index), 32'd3);
    drain();

    // Back-to-back words with in_valid held high
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    tick();
    in_data = 32'hCAFE_F00D;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("b2b_in_ready", 32'(bus_a.in_ready), 32'(k == 6));
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid", 32'(bus_a.out_valid), 32'd1);
    check("b2b_index", 32'(bus_a.out_index), 32'd0);
    check("b2b_data", 32'(bus_a.out_data), 32'(chunk_of(32'hCAFE_F00D, 0)));
    drain();

    // Reset mid-word at index 3
    start_word(32'hA5A5_5A5A);
    tick();
    tick();
    tick();
    check("pre_reset_index", 32'(bus_a.out_index), 32'd3);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_word_reset");
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_valid", {30'd0, bus_a.out_valid, bus_b.out_valid}, 32'd0);
      tick();
    end

    // Input changes right after acceptance must not leak into chunks
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    in_data  = 32'h0;
    expect_word("held_word", 32'hFFFF_FFFF);

    // Random traffic checked by the model
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    @(negedge clk);
    check("model_empty", 32'(qa.size() + qb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
